// File: rtl/pu_msp430_dac_sched.sv
// rtl/pu_msp430_dac_sched.sv - round-robin scheduler feeding four requesters into one serial DAC
module pu_msp430_dac_sched #(
    parameter logic [15:0] DAC_BASE = 16'h0190,
    parameter int          TMO      = 255
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic [3:0]  req,
    input  logic [55:0] req_data,
    output logic [3:0]  ack,
    output logic        err,
    output logic        busy,
    output logic [13:0] per_addr,
    output logic [15:0] per_din,
    output logic        per_en,
    output logic [1:0]  per_we,
    input  logic [15:0] per_dout
);

    localparam logic [13:0] DATA_ADDR = DAC_BASE[14:1];
    localparam logic [13:0] STAT_ADDR = DAC_BASE[14:1] + 14'd1;
    localparam logic [7:0]  TMO_LAST  = 8'(TMO - 1);

    typedef enum logic [2:0] {
        IDLE, GRANT, WRITE, WAIT_START, WAIT_END, ACK
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_q, rr_d;
    logic [1:0]  idx_q, idx_d;
    logic [13:0] data_q, data_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [1:0]  win;
    logic [1:0]  cand;
    logic        found;
    logic        frame_active;
    logic        unused_dout;

    assign frame_active = per_dout[0];
    assign unused_dout  = ^per_dout[15:1];

    // First requester at or after the round-robin pointer, wrapping 3->0.
    always_comb begin
        win   = rr_q;
        cand  = rr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = rr_q + i[1:0];
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q <= IDLE;
            rr_q    <= 2'd0;
            idx_q   <= 2'd0;
            data_q  <= 14'd0;
            tmo_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        idx_d    = idx_q;
        data_d   = data_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        ack      = 4'd0;
        err      = 1'b0;
        per_en   = 1'b0;
        per_we   = 2'b00;
        per_addr = 14'd0;
        per_din  = 16'd0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = win;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                data_d  = req_data[idx_q*14 +: 14];
                err_d   = 1'b0;
                state_d = WRITE;
            end
            WRITE: begin
                per_en   = 1'b1;
                per_we   = 2'b11;
                per_addr = DATA_ADDR;
                per_din  = {2'b00, data_q};
                tmo_d    = 8'd0;
                state_d  = WAIT_START;
            end
            WAIT_START, WAIT_END: begin
                per_en   = 1'b1;
                per_addr = STAT_ADDR;
                // Success takes priority over a timeout landing in the same cycle.
                if ((state_q == WAIT_START) && frame_active) begin
                    tmo_d   = 8'd0;
                    state_d = WAIT_END;
                end else if ((state_q == WAIT_END) && !frame_active) begin
                    state_d = ACK;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ACK: begin
                ack[idx_q] = 1'b1;
                err        = err_q;
                rr_d       = idx_q + 2'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: doc/pu_msp430_dac_sched.md
PU_MSP430_DAC_SCHED -- requirements
Module: pu_msp430_dac_sched

Interface
REQ-001 SHALL have parameter DAC_BASE, default 16'h0190, meaning byte base address of the serial DAC peripheral.
REQ-002 SHALL have parameter TMO, default 255, meaning poll timeout in mclk cycles, legal range 1..255.
REQ-003 SHALL have port mclk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port puc_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, 4 bits: per-requester update request, level.
REQ-006 SHALL have port req_data, input, 56 bits: requester n occupies bits [14n+13:14n] = {pd1, pd0, val[11:0]}.
REQ-007 SHALL have port ack, output, 4 bits: one-cycle pulse to the served requester on completion.
REQ-008 SHALL have port err, output, 1 bit: one-cycle pulse coincident with ack when the transfer timed out.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-010 SHALL have port per_addr, output, 14 bits: word address to DAC.
REQ-011 SHALL have port per_din, output, 16 bits: write data to DAC.
REQ-012 SHALL have port per_en, output, 1 bit: bus access strobe.
REQ-013 SHALL have port per_we, output, 2 bits: byte write enables.
REQ-014 SHALL have port per_dout, input, 16 bits: DAC read data, valid combinationally in the per_en cycle.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, WRITE, WAIT_START, WAIT_END, ACK.
REQ-016 SHALL arbitrate round-robin in IDLE when |req: first requester at or after pointer rr (wrapping 3->0) with req high; rr resets to 0 and becomes granted+1 mod 4 in ACK.
REQ-017 SHALL, in GRANT, capture the winner's 14-bit req_data slice and index into internal registers; requesters must hold req and data stable until ack.
REQ-018 SHALL, in WRITE (exactly one cycle), drive per_en=1, per_we=2'b11, per_addr=DAC_BASE[14:1], per_din={2'b00, pd1, pd0, val}.
REQ-019 SHALL, in WAIT_START and WAIT_END, issue one status read every cycle: per_en=1, per_we=2'b00, per_addr=DAC_BASE[14:1]+1, sampling per_dout[0] (frame active) in the same cycle.
REQ-020 SHALL leave WAIT_START for WAIT_END when the sampled bit is 1, and leave WAIT_END for ACK when the sampled bit is 0.
REQ-021 SHALL hold per_en=0, per_we=0, per_addr=0, per_din=0 in IDLE, GRANT and ACK.
REQ-022 SHALL use an 8-bit timeout counter cleared on entry to WAIT_START and again on entry to WAIT_END, incremented each cycle in those states; reaching TMO SHALL force ACK with the err flag set.
REQ-023 SHALL, in ACK (one cycle), pulse ack[granted]=1, pulse err if timed out, then return to IDLE; minimum gap between two grants is therefore one IDLE cycle.
REQ-024 SHALL ignore req changes while not IDLE; a requester dropping req mid-transfer still receives ack.
REQ-025 SHALL drive busy=1 from GRANT through ACK inclusive.

Reset
REQ-026 SHALL, on puc_rst_n low, asynchronously force state=IDLE, rr=0, timeout=0, captured data=0, and ack=0, err=0, busy=0, per_en=0, per_we=0, per_addr=0, per_din=0.
REQ-027 SHALL abandon any in-flight transfer on reset without issuing ack; the DAC itself is reset separately.

Verification
REQ-028 Single request: req=4'b0001, slice0=14'h2ABC with DAC model -> one write, per_din=16'h2ABC, per_addr=14'h00C8; status polls on 14'h00C9 until 1 then 0; ack=4'b0001 for one cycle; err=0.
REQ-029 Round-robin: req=4'b1111 held, re-asserted after each ack -> grant order 0,1,2,3,0; four acks with no requester served twice in a row.
REQ-030 Timeout: per_dout tied to 0 -> after TMO status reads in WAIT_START, ack and err pulse together; busy falls in the next cycle.
REQ-031 Mid-transfer request change: grant 2; raise req[1] and drop req[2] during WAIT_END -> ack[2] still pulses; next grant is 1 only after rr wraps past 3 and 0.
REQ-032 Reset mid-operation: assert puc_rst_n=0 in WAIT_END -> all outputs 0 immediately, no ack; after release with req=4'b0100, requester 2 is granted first.
